// File: rtl/mem_arb_pkg.sv
// Shared core definitions for the memory arbiter: response owner encoding
// and the SRAM read latency the response pipeline is sized from.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INS  = 2'd1,
    OWN_DAT  = 2'd2
  } owner_t;

  localparam int READ_LAT = 1;

endpackage

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter in front of a single-port SRAM with 1-cycle reads.
// Define MEM_ARB_RR_EN for round-robin contention; default is data priority with a starvation escape.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_a,
  input  logic          i_kill,
  output logic          i_gnt,
  output logic          i_vld,
  output logic [DW-1:0] i_rd,
  input  logic          d_req,
  input  logic [AW-1:0] d_a,
  input  logic [3:0]    d_we,
  input  logic [DW-1:0] d_wd,
  input  logic [3:0]    d_re,
  output logic          d_gnt,
  output logic          d_vld,
  output logic [DW-1:0] d_rd,
  output logic          m_e,
  output logic [AW-1:0] m_a,
  output logic [3:0]    m_we,
  output logic [DW-1:0] m_wd,
  output logic [3:0]    m_re,
  input  logic [DW-1:0] m_rd
);

  logic   grant_ins;
  logic   grant_dat;
  owner_t own_pipe  [READ_LAT];
  logic   kill_pipe [READ_LAT];
  owner_t resp_own;
  logic   resp_kill;

`ifdef MEM_ARB_RR_EN
  owner_t rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= OWN_INS;
    end else if (i_req && d_req) begin
      rr_ptr <= (rr_ptr == OWN_INS) ? OWN_DAT : OWN_INS;
    end
  end

  always_comb begin
    grant_ins = 1'b0;
    grant_dat = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (rr_ptr == OWN_INS) grant_ins = 1'b1;
        else                   grant_dat = 1'b1;
      end else begin
        grant_ins = i_req;
        grant_dat = d_req;
      end
    end
  end
`else
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_ins) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Data wins contention until the fetch port has been refused STARVE_MAX times in a row.
  always_comb begin
    grant_ins = 1'b0;
    grant_dat = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (starve_cnt == STARVE_LIM) grant_ins = 1'b1;
        else                          grant_dat = 1'b1;
      end else begin
        grant_ins = i_req;
        grant_dat = d_req;
      end
    end
  end
`endif

  assign i_gnt = grant_ins;
  assign d_gnt = grant_dat;

  always_comb begin
    m_e  = 1'b0;
    m_a  = '0;
    m_we = 4'h0;
    m_wd = '0;
    m_re = 4'h0;
    if (grant_ins) begin
      m_e  = 1'b1;
      m_a  = i_a;
      m_re = 4'hF;
    end else if (grant_dat) begin
      m_e  = 1'b1;
      m_a  = d_a;
      m_we = d_we;
      m_wd = d_wd;
      m_re = d_re;
    end
  end

  // Owner and kill flag travel alongside the SRAM read so the response lands on the right port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) begin
        own_pipe[k]  <= OWN_NONE;
        kill_pipe[k] <= 1'b0;
      end
    end else begin
      if (grant_ins)      own_pipe[0] <= OWN_INS;
      else if (grant_dat) own_pipe[0] <= OWN_DAT;
      else                own_pipe[0] <= OWN_NONE;
      kill_pipe[0] <= grant_ins && i_kill;
      for (int k = 1; k < READ_LAT; k++) begin
        own_pipe[k]  <= own_pipe[k-1];
        kill_pipe[k] <= kill_pipe[k-1] || i_kill;
      end
    end
  end

  assign resp_own  = own_pipe[READ_LAT-1];
  assign resp_kill = kill_pipe[READ_LAT-1];

  assign i_vld = !rst && (resp_own == OWN_INS) && !resp_kill && !i_kill;
  assign d_vld = !rst && (resp_own == OWN_DAT);
  assign i_rd  = i_vld ? m_rd : '0;
  assign d_rd  = d_vld ? m_rd : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a small behavioural SRAM;
// contention expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_kill, i_gnt, i_vld;
  logic [15:0] i_a;
  logic [31:0] i_rd;
  logic        d_req, d_gnt, d_vld;
  logic [15:0] d_a;
  logic [3:0]  d_we, d_re;
  logic [31:0] d_wd, d_rd;
  logic        m_e;
  logic [15:0] m_a;
  logic [3:0]  m_we, m_re;
  logic [31:0] m_wd, m_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_arb #(.AW(16), .DW(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_a(i_a), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_vld(i_vld), .i_rd(i_rd),
    .d_req(d_req), .d_a(d_a), .d_we(d_we), .d_wd(d_wd), .d_re(d_re),
    .d_gnt(d_gnt), .d_vld(d_vld), .d_rd(d_rd),
    .m_e(m_e), .m_a(m_a), .m_we(m_we), .m_wd(m_wd), .m_re(m_re), .m_rd(m_rd)
  );

  // Single-port SRAM: byte-masked writes, registered read data one cycle later.
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8'h10] = 32'h00000013;
    m_rd = 32'h0;
  end

  always @(posedge clk) begin
    if (m_e) begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_a[7:0]][8*b +: 8] <= m_wd[8*b +: 8];
      if (|m_re) m_rd <= mem[m_a[7:0]];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic applyStimulus(input logic r, input logic ireq, input logic [15:0] ia,
                               input logic ikill, input logic dreq, input logic [15:0] da,
                               input logic [3:0] dwe, input logic [31:0] dwd,
                               input logic [3:0] dre);
    @(negedge clk);
    rst = r; i_req = ireq; i_a = ia; i_kill = ikill;
    d_req = dreq; d_a = da; d_we = dwe; d_wd = dwd; d_re = dre;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  logic [1:0] exp_seq [6];
  logic [1:0] prev;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
`endif

    // Reset with both ports requesting: nothing may be granted.
    applyStimulus(1, 1, 16'h0010, 0, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
    applyStimulus(1, 1, 16'h0010, 0, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
    checkOutput("rst_i_gnt", i_gnt, 0);
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_m_e",   m_e,   0);
    checkOutput("rst_i_vld", i_vld, 0);
    checkOutput("rst_d_vld", d_vld, 0);

    // Sole fetch request.
    applyStimulus(0, 1, 16'h0010, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("fetch_i_gnt", i_gnt, 1);
    checkOutput("fetch_d_gnt", d_gnt, 0);
    checkOutput("fetch_m_e",   m_e,   1);
    checkOutput("fetch_m_a",   m_a,   32'h0010);
    checkOutput("fetch_m_we",  m_we,  32'h0);
    checkOutput("fetch_m_re",  m_re,  32'hF);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("fetch_i_vld", i_vld, 1);
    checkOutput("fetch_i_rd",  i_rd,  32'h00000013);
    checkOutput("fetch_d_vld", d_vld, 0);
    checkOutput("idle_m_e",    m_e,   0);

    // Data write, then back-to-back read of the same word.
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0040, 4'hF, 32'hDEADBEEF, 4'h0);
    checkOutput("wr_d_gnt", d_gnt, 1);
    checkOutput("wr_i_gnt", i_gnt, 0);
    checkOutput("wr_m_a",   m_a,   32'h0040);
    checkOutput("wr_m_we",  m_we,  32'hF);
    checkOutput("wr_m_wd",  m_wd,  32'hDEADBEEF);
    checkOutput("wr_m_re",  m_re,  32'h0);
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
    checkOutput("wr_ack",   d_vld, 1);
    checkOutput("rd_d_gnt", d_gnt, 1);
    checkOutput("rd_m_re",  m_re,  32'hF);
    checkOutput("rd_m_we",  m_we,  32'h0);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("rd_d_vld", d_vld, 1);
    checkOutput("rd_d_rd",  d_rd,  32'hDEADBEEF);
    checkOutput("rd_i_vld", i_vld, 0);

    // Both ports requesting for six cycles; {i_gnt,d_gnt} follows the policy.
    prev = 2'b00;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(0, 1, 16'h0010, 0, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
      checkOutput($sformatf("cont_gnt%0d", c), {i_gnt, d_gnt}, exp_seq[c]);
      checkOutput($sformatf("cont_vld%0d", c), {i_vld, d_vld}, prev);
      if (prev == 2'b10) checkOutput($sformatf("cont_i_rd%0d", c), i_rd, 32'h00000013);
      if (prev == 2'b01) checkOutput($sformatf("cont_d_rd%0d", c), d_rd, 32'hDEADBEEF);
      prev = exp_seq[c];
    end
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("cont_vld_last", {i_vld, d_vld}, prev);

    // Kill in the response cycle while a data read is granted.
    applyStimulus(0, 1, 16'h0010, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("kill_i_gnt", i_gnt, 1);
    applyStimulus(0, 0, 16'h0, 1, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
    checkOutput("kill_i_vld", i_vld, 0);
    checkOutput("kill_i_rd",  i_rd,  32'h0);
    checkOutput("kill_d_gnt", d_gnt, 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("kill_d_vld", d_vld, 1);
    checkOutput("kill_d_rd",  d_rd,  32'hDEADBEEF);

    // Kill in the grant cycle does not block the grant but drops its response.
    applyStimulus(0, 1, 16'h0010, 1, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("kill0_i_gnt", i_gnt, 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("kill0_i_vld", i_vld, 0);

    // Reset right after a data read grant discards its response.
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0040, 4'h0, 32'h0, 4'hF);
    checkOutput("rr_d_gnt", d_gnt, 1);
    applyStimulus(1, 1, 16'h0010, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("rstmid_d_vld", d_vld, 0);
    checkOutput("rstmid_d_rd",  d_rd,  32'h0);
    checkOutput("rstmid_i_gnt", i_gnt, 0);
    checkOutput("rstmid_m_e",   m_e,   0);
    checkOutput("rstmid_i_vld", i_vld, 0);
    applyStimulus(0, 1, 16'h0010, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("post_d_vld", d_vld, 0);
    checkOutput("post_i_gnt", i_gnt, 1);
    checkOutput("post_m_a",   m_a,   32'h0010);
    applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 4'h0, 32'h0, 4'h0);
    checkOutput("post_i_vld", i_vld, 1);
    checkOutput("post_i_rd",  i_rd,  32'h00000013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 16, SRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, maximum consecutive cycles the instruction port may be refused under fixed priority.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports i_req input 1, fetch request; i_a input AW, fetch address; i_kill input 1, discard in-flight fetch response.
REQ-007 SHALL have ports i_gnt output 1, fetch accepted this cycle; i_vld output 1, fetch data valid; i_rd output DW, fetch data.
REQ-008 SHALL have ports d_req input 1, d_a input AW, d_we input 4, d_wd input DW, d_re input 4: data request, address, byte write enables, write data and byte read enables.
REQ-009 SHALL have ports d_gnt output 1, data accepted; d_vld output 1, data response (read data or write ack); d_rd output DW.
REQ-010 SHALL have ports m_e output 1, m_a output AW, m_we output 4, m_wd output DW, m_re output 4, m_rd input DW: single-port SRAM with 1-cycle read latency.

Function
REQ-011 SHALL issue at most one SRAM access per cycle; m_e=1 exactly when i_gnt or d_gnt is 1; i_gnt and d_gnt SHALL never both be 1.
REQ-012 SHALL grant combinationally in the request cycle; m_a/m_we/m_wd/m_re SHALL carry the granted requester's fields; fetch drives m_we=0, m_re=4'hF.
REQ-013 SHALL require requesters to hold req and all fields stable until gnt; a req dropped before gnt is not an error and issues nothing.
REQ-014 SHALL support back-to-back grants every cycle with no bubble, including alternating owners.
REQ-015 SHALL register owner (NONE/INS/DAT) at each grant; the next cycle SHALL assert i_vld or d_vld for that owner with i_rd/d_rd = m_rd.
REQ-016 SHALL assert d_vld one cycle after a data write grant as acknowledgement; d_rd is don't-care then.
REQ-017 SHALL suppress i_vld for an in-flight fetch when i_kill=1 in the grant cycle or the response cycle; i_kill does not block a same-cycle new grant.
REQ-018 SHALL, with both requesting under fixed priority, grant data unless the starvation counter equals STARVE_MAX, then grant instruction.
REQ-019 SHALL increment the starvation counter each cycle i_req=1 without i_gnt, saturating at STARVE_MAX, and clear it on i_gnt or i_req=0.
REQ-020 SHALL grant a sole requester in the same cycle regardless of policy.
REQ-021 SHALL drive i_rd/d_rd to zero when the matching vld is 0.

Reset
REQ-022 SHALL, while rst=1, force owner=NONE, starvation counter=0, round-robin pointer=INS; i_gnt, d_gnt, m_e, i_vld, d_vld SHALL be 0.
REQ-023 SHALL drop any response in flight when rst asserts; no vld after reset release for pre-reset grants.

Configuration
REQ-024 SHALL, with MEM_ARB_RR_EN defined, replace REQ-018/019 with round-robin: on contention grant the pointer's port, then point to the other; the starvation counter is not built.
REQ-025 SHALL, without MEM_ARB_RR_EN, use the fixed data priority with starvation escape of REQ-018/019.

Structure
REQ-026 SHALL take the owner enum (NONE/INS/DAT) and the read-latency constant (1) from the shared core package.
REQ-027 SHALL be a single module; the arbitration policy is one always block and needs no sub-module.

Verification
REQ-028 SHALL test: i_req=1 only, i_a=16'h0010, m_rd=32'h00000013 -> i_gnt same cycle, i_vld=1 with i_rd=32'h00000013 next cycle.
REQ-029 SHALL test: d_req write d_a=16'h0040, d_we=4'hF, d_wd=32'hDEADBEEF, then read d_re=4'hF -> d_vld ack cycle+1, later d_rd=32'hDEADBEEF.
REQ-030 SHALL test: fixed priority, both req held 6 cycles, STARVE_MAX=3 -> grants D,D,D,I,D,D.
REQ-031 SHALL test: MEM_ARB_RR_EN defined, both req held 4 cycles -> grants I,D,I,D.
REQ-032 SHALL test: fetch granted, i_kill=1 next cycle -> i_vld stays 0; concurrent d_vld unaffected.
REQ-033 SHALL test: rst=1 in cycle after a data read grant -> d_vld=0, all outputs 0, first grant after release behaves as REQ-028.
